// File: rtl/lut_load_ctrl.sv
// lut_load_ctrl: sequences writes and readbacks over the shared port B of the
// four BPM lookup tables. One transfer runs at a time, is started by
// start_strb and can be cut short by abort_strb.
module lut_load_ctrl #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 7,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_strb,
  input  logic              mode,
  input  logic [1:0]        lut_sel,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] count_m1,
  input  logic              abort_strb,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] lut_dinb,
  output logic [ADDR_W-1:0] lut_addrb,
  output logic [3:0]        lut_web,
  input  logic [DATA_W-1:0] lut_doutb0,
  input  logic [DATA_W-1:0] lut_doutb1,
  input  logic [DATA_W-1:0] lut_doutb2,
  input  logic [DATA_W-1:0] lut_doutb3,
  output logic              lut_cond,
  output logic              busy,
  output logic              done_strb,
  output logic              abort_flag
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WRITE    = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_WAIT  = 3'd3,
    S_RD_HOLD  = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          sel_q, sel_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [1:0]          wait_q, wait_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [ADDR_W-1:0]   addrb_q, addrb_d;
  logic [DATA_W-1:0]   dinb_q, dinb_d;
  logic                abort_flag_q, abort_flag_d;

  logic                wr_ready_s;
  logic                rd_valid_s;
  logic [3:0]          web_s;
  logic                done_s;
  logic                step_s;
  logic                abort_s;
  logic [DATA_W-1:0]   doutb_sel_s;

  // Select the read data of the LUT targeted by the current transfer.
  always_comb begin
    case (sel_q)
      2'd0:    doutb_sel_s = lut_doutb0;
      2'd1:    doutb_sel_s = lut_doutb1;
      2'd2:    doutb_sel_s = lut_doutb2;
      2'd3:    doutb_sel_s = lut_doutb3;
      default: doutb_sel_s = lut_doutb0;
    endcase
  end

  // Next-state, datapath updates and handshake outputs; abort overrides all.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    addr_d       = addr_q;
    count_d      = count_q;
    wait_d       = wait_q;
    rd_data_d    = rd_data_q;
    addrb_d      = addrb_q;
    dinb_d       = dinb_q;
    abort_flag_d = abort_flag_q;
    wr_ready_s   = 1'b0;
    rd_valid_s   = 1'b0;
    web_s        = 4'b0000;
    done_s       = 1'b0;
    step_s       = 1'b0;
    abort_s      = abort_strb && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start_strb) begin
          sel_d        = lut_sel;
          addr_d       = start_addr;
          count_d      = count_m1;
          abort_flag_d = 1'b0;
          state_d      = mode ? S_RD_ISSUE : S_WRITE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        wr_ready_s = 1'b1;
        if (wr_valid) begin
          web_s[sel_q] = 1'b1;
          addrb_d      = addr_q;
          dinb_d       = wr_data;
          step_s       = 1'b1;
        end else begin
          step_s = 1'b0;
        end
      end
      S_RD_ISSUE: begin
        addrb_d = addr_q;
        wait_d  = 2'd0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // Port B data for the issued address is valid after RD_LAT cycles.
        if (wait_q == 2'(RD_LAT - 1)) begin
          rd_data_d = doutb_sel_s;
          state_d   = S_RD_HOLD;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      S_RD_HOLD: begin
        rd_valid_s = 1'b1;
        step_s     = rd_ready;
      end
      S_DONE: begin
        done_s  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // One word finished: either the last one, or advance to the next address.
    if (step_s) begin
      if (count_q == '0) begin
        state_d = S_DONE;
      end else begin
        addr_d  = addr_q + ADDR_W'(1);
        count_d = count_q - ADDR_W'(1);
        state_d = (state_q == S_WRITE) ? S_WRITE : S_RD_ISSUE;
      end
    end else begin
      addr_d = addr_d;
    end

    // Abort squashes the current cycle's write, handshakes and done pulse.
    if (abort_s) begin
      state_d      = S_IDLE;
      web_s        = 4'b0000;
      wr_ready_s   = 1'b0;
      rd_valid_s   = 1'b0;
      done_s       = 1'b0;
      addrb_d      = addrb_q;
      dinb_d       = dinb_q;
      abort_flag_d = 1'b1;
    end else begin
      abort_flag_d = abort_flag_d;
    end
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sel_q        <= 2'd0;
      addr_q       <= '0;
      count_q      <= '0;
      wait_q       <= 2'd0;
      rd_data_q    <= '0;
      addrb_q      <= '0;
      dinb_q       <= '0;
      abort_flag_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      wait_q       <= wait_d;
      rd_data_q    <= rd_data_d;
      addrb_q      <= addrb_d;
      dinb_q       <= dinb_d;
      abort_flag_q <= abort_flag_d;
    end
  end

  // Port B address/data follow the write or issue in the same cycle and
  // otherwise hold their last driven value.
  assign lut_addrb  = addrb_d;
  assign lut_dinb   = dinb_d;
  assign lut_web    = web_s;
  assign wr_ready   = wr_ready_s;
  assign rd_valid   = rd_valid_s;
  assign rd_data    = rd_data_q;
  assign done_strb  = done_s;
  assign busy       = (state_q != S_IDLE);
  assign lut_cond   = (state_q == S_IDLE);
  assign abort_flag = abort_flag_q;

endmodule

// File: tb/tb_lut_load_ctrl.sv
// Scoreboard bench for lut_load_ctrl: stimulus pushes expected port-B writes,
// readback words and done pulses; a monitor pops and compares them.
module tb_lut_load_ctrl;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 7;
  localparam int K_WR   = 0;
  localparam int K_RD   = 1;
  localparam int K_DONE = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_strb, mode, abort_strb, wr_valid, rd_ready;
  logic [1:0]        lut_sel;
  logic [ADDR_W-1:0] start_addr, count_m1;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready, rd_valid, lut_cond, busy, done_strb, abort_flag;
  logic [DATA_W-1:0] rd_data, lut_dinb;
  logic [ADDR_W-1:0] lut_addrb;
  logic [3:0]        lut_web;
  logic [DATA_W-1:0] dout0, dout1, dout2, dout3;

  typedef struct {
    int                kind;
    logic [3:0]        web;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  lut_load_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .start_strb(start_strb), .mode(mode),
    .lut_sel(lut_sel), .start_addr(start_addr), .count_m1(count_m1),
    .abort_strb(abort_strb), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_ready(rd_ready), .lut_dinb(lut_dinb), .lut_addrb(lut_addrb),
    .lut_web(lut_web), .lut_doutb0(dout0), .lut_doutb1(dout1),
    .lut_doutb2(dout2), .lut_doutb3(dout3), .lut_cond(lut_cond),
    .busy(busy), .done_strb(done_strb), .abort_flag(abort_flag)
  );

  always #5 clk = ~clk;

  // LUT read model, latency 1: LUT n returns addr[6:0] + n*0x10.
  always @(posedge clk) begin
    dout0 <= lut_addrb[6:0] + 7'h00;
    dout1 <= lut_addrb[6:0] + 7'h10;
    dout2 <= lut_addrb[6:0] + 7'h20;
    dout3 <= lut_addrb[6:0] + 7'h30;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  task automatic push(input int kind, input logic [3:0] web,
                      input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    exp_t e;
    e.kind = kind; e.web = web; e.addr = addr; e.data = data;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare against what the DUT presents.
  task automatic take(input int kind);
    exp_t e;
    if (sb.size() == 0) begin
      check($sformatf("unexpected_event_kind%0d", kind), 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("event_kind", kind, e.kind);
      if (kind == K_WR) begin
        check("wr_web",  {28'd0, lut_web}, {28'd0, e.web});
        check("wr_addr", {17'd0, lut_addrb}, {17'd0, e.addr});
        check("wr_data", {25'd0, lut_dinb}, {25'd0, e.data});
      end else if (kind == K_RD) begin
        check("rd_data", {25'd0, rd_data}, {25'd0, e.data});
      end else begin
        check("done_lut_cond", {31'd0, lut_cond}, 32'd0);
      end
    end
  endtask

  // Monitor: every output event is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (lut_web != 4'b0000) take(K_WR);
      if (rd_valid && rd_ready) take(K_RD);
      if (done_strb) take(K_DONE);
    end
  end

  task automatic start(input logic m, input logic [1:0] sel,
                       input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] c);
    @(posedge clk); #1;
    start_strb = 1'b1; mode = m; lut_sel = sel; start_addr = a; count_m1 = c;
    @(posedge clk); #1;
    start_strb = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy) check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic wait_rd_valid(input string name, input int budget);
    int n = 0;
    @(negedge clk);
    while (!rd_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!rd_valid) check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start_strb = 1'b0; mode = 1'b0; lut_sel = 2'd0;
    start_addr = '0; count_m1 = '0; abort_strb = 1'b0; wr_valid = 1'b0;
    wr_data = '0; rd_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_rd_data", {25'd0, rd_data}, 32'd0);
    check("rst_web", {28'd0, lut_web}, 32'd0);
    check("rst_addrb", {17'd0, lut_addrb}, 32'd0);
    check("rst_dinb", {25'd0, lut_dinb}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_lut_cond", {31'd0, lut_cond}, 32'd1);
    check("rst_abort_flag", {31'd0, abort_flag}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Write load: LUT 2, addresses 0x10..0x13, back-to-back words.
    for (int i = 0; i < 4; i++) push(K_WR, 4'b0100, 15'h0010 + 15'(i), 7'(i + 1));
    push(K_DONE, 4'b0000, 15'h0, 7'h0);
    start(1'b0, 2'd2, 15'h0010, 15'd3);
    wr_valid = 1'b1; wr_data = 7'h01;
    #3; check("load_lut_cond_busy", {31'd0, lut_cond}, 32'd0);
    for (int i = 2; i <= 4; i++) begin
      @(posedge clk); #1; wr_data = 7'(i);
    end
    @(posedge clk); #1; wr_valid = 1'b0;
    wait_idle("load", 10);
    check("load_sb_empty", sb.size(), 32'd0);
    check("load_lut_cond_idle", {31'd0, lut_cond}, 32'd1);

    // Address wrap-around from all-ones to zero.
    push(K_WR, 4'b0001, 15'h7FFE, 7'h11);
    push(K_WR, 4'b0001, 15'h7FFF, 7'h12);
    push(K_WR, 4'b0001, 15'h0000, 7'h13);
    push(K_DONE, 4'b0000, 15'h0, 7'h0);
    start(1'b0, 2'd0, 15'h7FFE, 15'd2);
    wr_valid = 1'b1; wr_data = 7'h11;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1; wr_data = wr_data + 7'h01;
    end
    @(posedge clk); #1; wr_valid = 1'b0;
    wait_idle("wrap", 10);
    check("wrap_sb_empty", sb.size(), 32'd0);

    // Readback from LUT 1 at 0x20 with back-pressure: words 0x30, 0x31.
    push(K_RD, 4'b0000, 15'h0, 7'h30);
    push(K_RD, 4'b0000, 15'h0, 7'h31);
    push(K_DONE, 4'b0000, 15'h0, 7'h0);
    start(1'b1, 2'd1, 15'h0020, 15'd1);
    wait_rd_valid("rd_first", 10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rd_hold_valid", {31'd0, rd_valid}, 32'd1);
      check("rd_hold_data", {25'd0, rd_data}, 32'h30);
    end
    @(posedge clk); #1; rd_ready = 1'b1;
    wait_idle("rd", 20);
    rd_ready = 1'b0;
    check("rd_sb_empty", sb.size(), 32'd0);

    // Abort on the second write handshake of a 4-word load.
    push(K_WR, 4'b1000, 15'h0100, 7'h21);
    start(1'b0, 2'd3, 15'h0100, 15'd3);
    wr_valid = 1'b1; wr_data = 7'h21;
    @(posedge clk); #1; wr_data = 7'h22; abort_strb = 1'b1;
    @(negedge clk);
    check("abort_web", {28'd0, lut_web}, 32'd0);
    check("abort_wr_ready", {31'd0, wr_ready}, 32'd0);
    @(posedge clk); #1; abort_strb = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_flag_set", {31'd0, abort_flag}, 32'd1);
    repeat (3) @(negedge clk);
    check("abort_flag_held", {31'd0, abort_flag}, 32'd1);
    check("abort_sb_empty", sb.size(), 32'd0);

    // Abort in IDLE has no effect.
    @(posedge clk); #1; abort_strb = 1'b1;
    @(posedge clk); #1; abort_strb = 1'b0;
    @(negedge clk);
    check("idle_abort_busy", {31'd0, busy}, 32'd0);

    // Start during a write to LUT 0 is ignored; abort_flag clears on start.
    push(K_WR, 4'b0001, 15'h0200, 7'h41);
    push(K_WR, 4'b0001, 15'h0201, 7'h42);
    push(K_WR, 4'b0001, 15'h0202, 7'h43);
    push(K_DONE, 4'b0000, 15'h0, 7'h0);
    start(1'b0, 2'd0, 15'h0200, 15'd2);
    wr_valid = 1'b1; wr_data = 7'h41;
    #3; check("start_clears_abort_flag", {31'd0, abort_flag}, 32'd0);
    @(posedge clk); #1; wr_data = 7'h42;
    start_strb = 1'b1; mode = 1'b1; lut_sel = 2'd3; start_addr = 15'h0555; count_m1 = 15'd0;
    @(posedge clk); #1; wr_data = 7'h43; start_strb = 1'b0;
    @(posedge clk); #1; wr_valid = 1'b0;
    wait_idle("ignored_start", 10);
    check("ignored_sb_empty", sb.size(), 32'd0);

    // Reset asserted while a readback word is held.
    start(1'b1, 2'd2, 15'h0030, 15'd0);
    wait_rd_valid("rst_rd", 10);
    #1; rst = 1'b1; #1;
    check("midrst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("midrst_lut_cond", {31'd0, lut_cond}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (3) @(negedge clk);
    check("postrst_busy", {31'd0, busy}, 32'd0);
    check("postrst_web", {28'd0, lut_web}, 32'd0);
    check("postrst_rd_data", {25'd0, rd_data}, 32'd0);
    check("final_sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
